// File: rtl/dispenser_controller.sv
// Water-dispense sequencer: owns the shared counter's reset, times valve-open
// and cooldown intervals from its count, and tallies completed dispenses.
module dispenser_controller #(
   parameter int unsigned BIT_COUNT       = 32,
   parameter int unsigned DISPENSE_CYCLES = 18,
   parameter int unsigned COOLDOWN_CYCLES = 5,
   parameter int unsigned TALLY_WIDTH     = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   button,
   input  logic                   cup_present,
   input  logic [BIT_COUNT-1:0]   count,
   output logic                   counter_reset,
   output logic                   valve_open,
   output logic                   ready,
   output logic                   done,
   output logic                   aborted,
   output logic [TALLY_WIDTH-1:0] tally
);

   localparam logic [BIT_COUNT-1:0] DISPENSE_LAST = BIT_COUNT'(DISPENSE_CYCLES - 1);
   localparam logic [BIT_COUNT-1:0] COOLDOWN_LAST = BIT_COUNT'(COOLDOWN_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DISPENSE = 2'd1,
      RESTART  = 2'd2,
      COOLDOWN = 2'd3
   } state_t;

   state_t state;
   logic   button_previous;
   logic   start;

   assign start = button & ~button_previous;

   // The only output that follows an input combinationally.
   assign ready = (state == IDLE) & cup_present;

   // Outputs are registered alongside the state so they always equal its decode.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         counter_reset   <= 1'b1;
         valve_open      <= 1'b0;
         done            <= 1'b0;
         aborted         <= 1'b0;
         tally           <= '0;
         button_previous <= 1'b1;
      end else begin
         button_previous <= button;
         done            <= 1'b0;
         aborted         <= 1'b0;
         case (state)
            IDLE: begin
               if (start && cup_present) begin
                  state         <= DISPENSE;
                  counter_reset <= 1'b0;
                  valve_open    <= 1'b1;
               end
            end
            DISPENSE: begin
               // Terminal count takes priority over cup removal.
               if (count >= DISPENSE_LAST) begin
                  state         <= RESTART;
                  counter_reset <= 1'b1;
                  valve_open    <= 1'b0;
                  done          <= 1'b1;
                  if (tally != '1) begin
                     tally <= tally + TALLY_WIDTH'(1);
                  end
               end else if (!cup_present) begin
                  state         <= RESTART;
                  counter_reset <= 1'b1;
                  valve_open    <= 1'b0;
                  aborted       <= 1'b1;
               end
            end
            RESTART: begin
               state         <= COOLDOWN;
               counter_reset <= 1'b0;
            end
            COOLDOWN: begin
               if (count >= COOLDOWN_LAST) begin
                  state         <= IDLE;
                  counter_reset <= 1'b1;
               end
            end
            default: begin
               state         <= IDLE;
               counter_reset <= 1'b1;
               valve_open    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dispenser_controller.sv
// Bench for dispenser_controller: a default instance and a 2-bit-tally instance
// share stimulus; expectations come from the cycle timing relative to the start edge.
module tb_dispenser_controller;

   typedef struct {
      bit valve;
      bit crst;
      bit rdy;
      bit dn;
      bit ab;
      int tally;
      int tally2;
   } exp_t;

   typedef struct {
      int abort_rel;  // 0 = no cup removal; else cycle offset where cup reads 0
      int mode;       // 0 = button pulse, 1 = held, 2 = extra pulses while busy
   } scn_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        button = 1'b0;
   logic        cup_present = 1'b1;
   logic [31:0] count, count2;
   logic        counter_reset, valve_open, ready, done, aborted;
   logic [15:0] tally;
   logic        counter_reset2, valve_open2, ready2, done2, aborted2;
   logic [1:0]  tally2;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   n_done = 0;
   exp_t sb[$];
   exp_t got_e;
   scn_t tbl[8];

   always #5 clock = ~clock;

   dispenser_controller dut (
      .clock(clock), .reset(reset), .button(button), .cup_present(cup_present),
      .count(count), .counter_reset(counter_reset), .valve_open(valve_open),
      .ready(ready), .done(done), .aborted(aborted), .tally(tally)
   );

   dispenser_controller #(.TALLY_WIDTH(2)) dut2 (
      .clock(clock), .reset(reset), .button(button), .cup_present(cup_present),
      .count(count2), .counter_reset(counter_reset2), .valve_open(valve_open2),
      .ready(ready2), .done(done2), .aborted(aborted2), .tally(tally2)
   );

   // Free-running counters with synchronous clear, as attached in the system.
   always_ff @(posedge clock) begin
      count  <= counter_reset  ? 32'd0 : count + 32'd1;
      count2 <= counter_reset2 ? 32'd0 : count2 + 32'd1;
   end

   task automatic chk(input string name, input int act, input int want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, want);
      end
   endtask

   always @(negedge clock) begin
      cyc++;
      if (sb.size() != 0) begin
         got_e = sb.pop_front();
         chk("valve_open", int'(valve_open), int'(got_e.valve));
         chk("counter_reset", int'(counter_reset), int'(got_e.crst));
         chk("ready", int'(ready), int'(got_e.rdy));
         chk("done", int'(done), int'(got_e.dn));
         chk("aborted", int'(aborted), int'(got_e.ab));
         chk("tally", int'(tally), got_e.tally);
         chk("valve_open2", int'(valve_open2), int'(got_e.valve));
         chk("counter_reset2", int'(counter_reset2), int'(got_e.crst));
         chk("ready2", int'(ready2), int'(got_e.rdy));
         chk("done2", int'(done2), int'(got_e.dn));
         chk("aborted2", int'(aborted2), int'(got_e.ab));
         chk("tally2", int'(tally2), got_e.tally2);
      end
   end

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   function automatic exp_t idle_exp(input bit cup, input int n);
      exp_t e;
      e.valve = 1'b0; e.crst = 1'b1; e.rdy = cup; e.dn = 1'b0; e.ab = 1'b0;
      e.tally = sat(n, 65535); e.tally2 = sat(n, 3);
      return e;
   endfunction

   // Expected outputs at offset r from the start cycle (r = 0 samples the edge).
   function automatic exp_t scn_exp(input int r, input int k, input int n);
      exp_t e;
      bit   comp  = (k == 0) || (k >= 18);
      int   lastv = comp ? 18 : k;
      int   rr    = lastv + 1;
      int   endr  = comp ? 25 : k + 7;
      bit   cup   = (k == 0) || (r < k);
      int   nn    = n + ((comp && r >= rr) ? 1 : 0);
      e.valve  = (r >= 1) && (r <= lastv);
      e.crst   = (r <= 0) || (r == rr) || (r >= endr);
      e.rdy    = ((r <= 0) || (r >= endr)) && cup;
      e.dn     = comp && (r == rr);
      e.ab     = !comp && (r == rr);
      e.tally  = sat(nn, 65535);
      e.tally2 = sat(nn, 3);
      return e;
   endfunction

   task automatic step(input bit b, input bit c, input exp_t e);
      @(posedge clock);
      #1;
      button = b;
      cup_present = c;
      sb.push_back(e);
   endtask

   task automatic run_scn(input scn_t s, input int last_r);
      int  k = s.abort_rel;
      bit  comp = (k == 0) || (k >= 18);
      int  endr = comp ? 25 : k + 7;
      int  stop = (last_r >= 0) ? last_r : endr + 2;
      bit  b;
      for (int r = -1; r <= stop; r++) begin
         if (r < 0)             b = 1'b0;
         else if (r == 0)       b = 1'b1;
         else if (s.mode == 1)  b = 1'b1;
         else if (s.mode == 2)  b = (r == 5) || (r == 21);
         else                   b = 1'b0;
         step(b, (k == 0) || (r < k), scn_exp(r, k, n_done));
      end
      if (last_r < 0 && comp) n_done++;
   endtask

   initial begin
      tbl[0] = '{abort_rel: 0,  mode: 0};   // normal dispense
      tbl[1] = '{abort_rel: 5,  mode: 0};   // cup pulled mid-dispense
      tbl[2] = '{abort_rel: 18, mode: 0};   // removal on terminal count: completion wins
      tbl[3] = '{abort_rel: 0,  mode: 1};   // button held through the whole cycle
      tbl[4] = '{abort_rel: 0,  mode: 2};   // edges during dispense and cooldown ignored
      tbl[5] = '{abort_rel: 1,  mode: 0};   // abort in first valve cycle
      tbl[6] = '{abort_rel: 0,  mode: 0};
      tbl[7] = '{abort_rel: 0,  mode: 0};   // sixth completion: 2-bit tally pinned at 3

      // Reset values while reset is held, with a button already high.
      button = 1'b1;
      repeat (3) @(posedge clock);
      #2;
      chk("rst_valve", int'(valve_open), 0);
      chk("rst_counter_reset", int'(counter_reset), 1);
      chk("rst_done", int'(done), 0);
      chk("rst_aborted", int'(aborted), 0);
      chk("rst_tally", int'(tally), 0);
      chk("rst_ready", int'(ready), 1);
      @(posedge clock);
      #1 reset = 1'b0;
      // Button held across reset release must not start a dispense.
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, idle_exp(1'b1, 0));

      for (int i = 0; i < 8; i++) run_scn(tbl[i], -1);

      // No cup: press discarded; cup arriving later without a new edge does nothing.
      step(1'b0, 1'b0, idle_exp(1'b0, n_done));
      step(1'b1, 1'b0, idle_exp(1'b0, n_done));
      step(1'b0, 1'b0, idle_exp(1'b0, n_done));
      step(1'b0, 1'b0, idle_exp(1'b0, n_done));
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, idle_exp(1'b1, n_done));
      step(1'b1, 1'b0, idle_exp(1'b0, n_done));
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, idle_exp(1'b1, n_done));

      // Reset mid-dispense at count 7: valve drops and counter_reset rises at once.
      run_scn('{abort_rel: 0, mode: 0}, 8);
      @(negedge clock);
      #2;
      reset  = 1'b1;
      button = 1'b1;
      #1;
      chk("async_valve", int'(valve_open), 0);
      chk("async_counter_reset", int'(counter_reset), 1);
      chk("async_tally", int'(tally), 0);
      chk("async_tally2", int'(tally2), 0);
      n_done = 0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, idle_exp(1'b1, 0));
      run_scn(tbl[0], -1);

      repeat (3) @(negedge clock);
      #1;
      chk("scoreboard_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dispenser_controller.md
# dispenser_controller

Sequencing FSM for one water-dispense cycle. It owns the reset of the shared free-running `counter` and reads its `count` to time two intervals: valve-open time, then a cooldown lockout. It sits between the debounced front-panel button and cup sensor and the valve driver, and keeps a saturating tally of completed dispenses.

## Interface
- `BIT_COUNT`, 32: width of the `count` input; must match the attached `counter` instance.
- `DISPENSE_CYCLES`, 18: clock cycles the valve stays open (360 ns at a 20 ns clock); legal range 1 .. 2^BIT_COUNT-1.
- `COOLDOWN_CYCLES`, 5: lockout cycles after a dispense or abort; legal range 1 .. 2^BIT_COUNT-1.
- `TALLY_WIDTH`, 16: width of the `tally` output.

Ports:
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces every register to its reset value.
- `button`  in  1  synchronized, debounced dispense request (level).
- `cup_present`  in  1  synchronized cup sensor; 1 = cup in place.
- `count`  in  BIT_COUNT  count from the `counter` driven by `counter_reset`.
- `counter_reset`  out  1  drives the `counter` reset port.
- `valve_open`  out  1  valve driver enable.
- `ready`  out  1  high when a button press would start a dispense.
- `done`  out  1  one-cycle pulse on normal completion.
- `aborted`  out  1  one-cycle pulse when the cup is removed mid-dispense.
- `tally`  out  TALLY_WIDTH  number of completed dispenses; saturates.

## Operation
- States: IDLE, DISPENSE, RESTART, COOLDOWN.
- Decode from the state register:
  - `counter_reset` = 1 in IDLE and RESTART.
  - `valve_open` = 1 only in DISPENSE.
  - `ready` = IDLE & `cup_present`.
- Edge detect: register `button_previous`. Start event = `button` & ~`button_previous`.
- IDLE -> DISPENSE: on a start event while `cup_present`=1. A start event without a cup is discarded, not queued.
- DISPENSE -> RESTART, normal: when `count` >= DISPENSE_CYCLES-1.
  - `done` is 1 during the RESTART cycle.
  - `tally` increments on that edge and saturates at all-ones.
- DISPENSE -> RESTART, abort: when `cup_present`=0 and the terminal count is not reached.
  - `aborted` is 1 during the RESTART cycle.
  - `tally` is unchanged.
- Simultaneous terminal count and cup removal: completion wins. `done`=1, `aborted`=0, tally increments.
- RESTART -> COOLDOWN: unconditional, after one cycle. This clears the counter.
- COOLDOWN -> IDLE: when `count` >= COOLDOWN_CYCLES-1.
- Start events outside IDLE are ignored. A button held high across COOLDOWN does not retrigger; a new rising edge is required.
- The `>=` compares are deliberate: a stray count past target still terminates the state and never hangs.
- Reset values:
  - state IDLE.
  - `counter_reset`=1, `valve_open`=0, `done`=0, `aborted`=0.
  - `tally`=0.
  - `button_previous`=1, so a button held through reset release does not start a dispense.
- Reset asserted mid-operation: valve closes asynchronously, `counter_reset` rises, and the FSM returns to IDLE. `tally` clears.

## Timing
- Let cycle t be the cycle in which the start event and `cup_present`=1 are sampled.
- `valve_open` is high in cycles t+1 .. t+DISPENSE_CYCLES, exactly DISPENSE_CYCLES cycles.
- The `counter` reads 0 in cycle t+1 (held in reset through cycle t), then counts 1, 2, ... per cycle.
- RESTART occupies t+DISPENSE_CYCLES+1; `done` pulses in that cycle. `tally` holds the new value from t+DISPENSE_CYCLES+1 onward.
- COOLDOWN occupies t+DISPENSE_CYCLES+2 .. t+DISPENSE_CYCLES+COOLDOWN_CYCLES+1.
- IDLE, with `ready` = `cup_present`, from t+DISPENSE_CYCLES+COOLDOWN_CYCLES+2.
- Abort: cup removal sampled in cycle k of DISPENSE closes the valve from cycle k+1. `aborted` pulses in k+1; IDLE returns at k+COOLDOWN_CYCLES+2.
- Input-to-valve latency is 1 cycle. All outputs are glitch-free state decodes with no combinational path from inputs, except `ready`, which follows `cup_present` combinationally.

## Test plan
- Normal dispense, defaults: cup=1, button rises at cycle 10 -> `valve_open` high cycles 11..28 (18 cycles), `done` pulse at 29, `tally`=1, `ready`=1 again at 35.
- No cup: cup=0, button pulse -> `valve_open` stays 0, `counter_reset` stays 1, `tally`=0. Raising cup later without a new button edge -> no dispense.
- Abort: start at cycle 10, cup drops sampled in cycle 15 -> valve low from 16, `aborted` pulse at 16, `done` never, `tally` unchanged, IDLE at 22.
- Retrigger lockout:
  - Button held high from cycle 10 through cycle 40 -> exactly one dispense.
  - Second edge during COOLDOWN -> ignored.
  - Edge at cycle 40 -> second dispense; `tally`=2.
- Edge cases: cup removal coinciding with count == 17 -> `done`=1, `aborted`=0. `TALLY_WIDTH`=2 with 5 dispenses -> `tally` saturates at 3.
- Reset: assert `reset` mid-DISPENSE (count=7) -> `valve_open`=0 and `counter_reset`=1 asynchronously, `tally`=0. Button held across reset release -> no start until the next rising edge.
